// File: rtl/turn_signal_pkg.sv
// turn_signal_pkg: shared state type and lamp mask helper for the turn-signal sequencer.
package turn_signal_pkg;
    localparam int MAX_LAMPS = 32;
    typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF} state_t;
    // Thermometer mask: the s innermost lamps lit, clipped to the lamp count.
    function automatic logic [MAX_LAMPS-1:0] lamp_mask(input int s, input int lamps);
        logic [MAX_LAMPS-1:0] m;
        for (int i = 0; i < MAX_LAMPS; i++) m[i] = (i < s) && (i < lamps);
        return m;
    endfunction
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: wrapping 0..TICK_DIV-1 counter producing one tick per sequence step.
module step_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick  = (TICK_DIV == 1) || (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/turn_signal_seq.sv
// turn_signal_seq: sweeping turn-signal and hazard lamp sequencer with built-in step prescaler.
module turn_signal_seq
    import turn_signal_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    output logic [LAMPS-1:0] la,
    output logic [LAMPS-1:0] ra,
    output logic             active
);
    localparam int SW = $clog2(LAMPS + 1);
    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [LAMPS-1:0] la_q, ra_q, la_d, ra_d, mask;
    logic             active_q, active_d, tick;
    step_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        if (tick) begin
            case (state_q)
                LEFT, RIGHT: begin
                    if (hazard) begin
                        state_d = HAZ_ON;
                        s_d     = '0;
                    end else if (s_q < SW'(LAMPS)) begin
                        s_d = s_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        s_d     = '0;
                    end
                end
                HAZ_ON: state_d = HAZ_OFF;
                default: begin
                    state_d = hazard || (left && right) ? HAZ_ON :
                              left ? LEFT : right ? RIGHT : IDLE;
                    s_d     = !hazard && (left ^ right) ? SW'(1) : '0;
                end
            endcase
        end
    end
    // Outputs are decoded from the next state so lamps change on the same edge as the state.
    assign mask     = LAMPS'(lamp_mask(int'(s_d), LAMPS));
    assign la_d     = state_d == LEFT ? mask : state_d == HAZ_ON ? '1 : '0;
    assign ra_d     = state_d == RIGHT ? mask : state_d == HAZ_ON ? '1 : '0;
    assign active_d = state_d != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            la_q     <= '0;
            ra_q     <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            la_q     <= la_d;
            ra_q     <= ra_d;
            active_q <= active_d;
        end
    end
    assign la     = la_q;
    assign ra     = ra_q;
    assign active = active_q;
endmodule

// File: tb/tb_turn_signal_seq.sv
// tb_turn_signal_seq: directed and random checks of two sequencer configurations against a behavioural model.
module tb_turn_signal_seq;
    logic clk = 1'b0, reset = 1'b1, left = 1'b0, right = 1'b0, hazard = 1'b0;
    logic [2:0] la_a, ra_a;
    logic [4:0] la_b, ra_b;
    logic act_a, act_b;
    int checks = 0, failures = 0;
    int lmp[2] = '{3, 5};
    int dv[2]  = '{1, 4};
    int mode[2], n[2], cnt[2];
    int pat1[8] = '{1, 3, 7, 0, 1, 3, 7, 0};
    int pat2[5] = '{3, 7, 0, 0, 0};
    int pla3[5] = '{7, 0, 0, 0, 0};
    int pra3[5] = '{0, 0, 1, 3, 7};
    int patb[6] = '{1, 3, 7, 15, 31, 0};
    int act_cnt;

    turn_signal_seq #(.LAMPS(3), .TICK_DIV(1)) u_a (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .la(la_a), .ra(ra_a), .active(act_a));
    turn_signal_seq #(.LAMPS(5), .TICK_DIV(4)) u_b (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .la(la_b), .ra(ra_b), .active(act_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model modes: 0 idle, 1 left sweep, 2 right sweep, 3 hazard lit, 4 hazard dark.
    function automatic logic [31:0] exp_la(input int d);
        return mode[d] == 1 ? (1 << n[d]) - 1 : mode[d] == 3 ? (1 << lmp[d]) - 1 : 0;
    endfunction
    function automatic logic [31:0] exp_ra(input int d);
        return mode[d] == 2 ? (1 << n[d]) - 1 : mode[d] == 3 ? (1 << lmp[d]) - 1 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mode[d] = 0;
            n[d]    = 0;
            cnt[d]  = 0;
        end
    endtask

    task automatic model_edge(input logic l, input logic r, input logic h);
        for (int d = 0; d < 2; d++) begin
            if (cnt[d] % dv[d] == dv[d] - 1) begin
                if (mode[d] == 0 || mode[d] == 4) begin
                    if (h || (l && r)) mode[d] = 3;
                    else if (l) begin mode[d] = 1; n[d] = 1; end
                    else if (r) begin mode[d] = 2; n[d] = 1; end
                    else mode[d] = 0;
                end else if (mode[d] == 3) begin
                    mode[d] = 4;
                end else if (h) begin
                    mode[d] = 3;
                end else if (n[d] < lmp[d]) begin
                    n[d]++;
                end else begin
                    mode[d] = 0;
                end
            end
            cnt[d]++;
        end
    endtask

    task automatic check_all();
        chk("a_la", la_a, exp_la(0));
        chk("a_ra", ra_a, exp_ra(0));
        chk("a_active", act_a, mode[0] != 0);
        chk("b_la", la_b, exp_la(1));
        chk("b_ra", ra_b, exp_ra(1));
        chk("b_active", act_b, mode[1] != 0);
    endtask

    task automatic step();
        logic l, r, h;
        l = left;
        r = right;
        h = hazard;
        @(posedge clk);
        if (!reset) model_edge(l, r, h);
        #1;
        check_all();
    endtask

    task automatic areset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic do_reset();
        areset();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1;
        model_reset();
        check_all();
        step();
        reset = 1'b0;
        left = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("left_held", la_a, pat1[i]);
        end
        left = 1'b0;
        do_reset();
        left = 1'b1;
        step();
        chk("pulse_first", la_a, 1);
        left = 1'b0;
        act_cnt = act_a;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("pulse_sweep", la_a, pat2[i]);
            act_cnt += act_a;
        end
        chk("pulse_active_cycles", act_cnt, 3);
        do_reset();
        left = 1'b1;
        step();
        step();
        left  = 1'b0;
        right = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("opp_la", la_a, pla3[i]);
            chk("opp_ra", ra_a, pra3[i]);
        end
        right = 1'b0;
        do_reset();
        left = 1'b1;
        step();
        left   = 1'b0;
        hazard = 1'b1;
        step();
        chk("haz_on_la", la_a, 7);
        chk("haz_on_ra", ra_a, 7);
        step();
        chk("haz_off_la", la_a, 0);
        step();
        chk("haz_on2_ra", ra_a, 7);
        hazard = 1'b0;
        step();
        chk("haz_exit_dark", la_a, 0);
        chk("haz_exit_active", act_a, 1);
        step();
        chk("haz_idle_active", act_a, 0);
        do_reset();
        hazard = 1'b1;
        step();
        chk("pre_reset_haz", la_a, 7);
        hazard = 1'b0;
        areset();
        chk("async_la", la_a, 0);
        chk("async_active", act_a, 0);
        left  = 1'b1;
        right = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("both_haz_la", la_a, 7);
        chk("both_haz_ra", ra_a, 7);
        left  = 1'b0;
        right = 1'b0;
        do_reset();
        left = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step();
            chk("b_prescaled", la_b, k < 4 ? 0 : patb[((k - 4) / 4) % 6]);
        end
        left = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    left   = 1'($urandom_range(0, 1));
                    right  = 1'($urandom_range(0, 1));
                    hazard = $urandom_range(0, 7) == 0;
                end
                step();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
